// File: rtl/or_result_checker_pkg.sv
// Shared definitions for the OR-gate result checker: FSM state encoding,
// default stimulus width and the exhaustive sweep length for that width.
// Optional feature macro: CHECK_SEQ_EN (vector order checking).
package or_result_checker_pkg;

   // Default stimulus vector width; one sweep covers every vector of it
   localparam int DEFAULT_WIDTH = 10;

   // Number of beats in one exhaustive sweep at the default width
   localparam int SWEEP_LEN = 2 ** DEFAULT_WIDTH;

   // Sweep control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/or_result_checker_cmp.sv
// Stage 2 of the result checker: recomputes the expected OR reduction of the
// registered stimulus, compares it with the registered gate output and keeps
// the beat/error counters plus the first-failure capture.
// Optional feature macro: CHECK_SEQ_EN adds an expected-index counter and a
// sequence error counter so out-of-order or repeated vectors are detected.
module or_result_cmp
   import or_result_checker_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_result,
   output logic [CNT_W-1:0] o_total_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [WIDTH-1:0] o_first_err_data,
   output logic             o_first_err_valid
`ifdef CHECK_SEQ_EN
   ,
   output logic [CNT_W-1:0] o_seq_err_cnt
`endif
);

   logic             w_expected;
   logic             w_mismatch;
   logic [CNT_W-1:0] r_total_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [WIDTH-1:0] r_first_err_data;
   logic             r_first_err_valid;

   // Golden model of the gate under test: OR reduction of the vector
   always_comb begin
      w_expected = |i_data;
      w_mismatch = i_valid && (i_result != w_expected);
   end

   // Counters and first-failure capture; a clear (new sweep) behaves like reset.
   // The sweep length bounds every counter, so no saturation is needed.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_total_cnt       <= '0;
         r_err_cnt         <= '0;
         r_first_err_data  <= '0;
         r_first_err_valid <= 1'b0;
      end else if (i_valid) begin
         r_total_cnt <= r_total_cnt + 1'b1;
         if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + 1'b1;
            // Only the first failing vector is kept for debug
            if (!r_first_err_valid) begin
               r_first_err_data  <= i_data;
               r_first_err_valid <= 1'b1;
            end
         end
      end
   end

   assign o_total_cnt       = r_total_cnt;
   assign o_err_cnt         = r_err_cnt;
   assign o_first_err_data  = r_first_err_data;
   assign o_first_err_valid = r_first_err_valid;

`ifdef CHECK_SEQ_EN
   logic [WIDTH-1:0] r_exp_idx;
   logic [CNT_W-1:0] r_seq_err_cnt;
   logic             w_seq_mismatch;

   // The generator walks vectors 0,1,2,... so the expected vector is the beat index
   always_comb begin
      w_seq_mismatch = i_valid && (i_data != r_exp_idx);
   end

   // Expected-index tracking and sequence error counting
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_exp_idx     <= '0;
         r_seq_err_cnt <= '0;
      end else if (i_valid) begin
         r_exp_idx <= r_exp_idx + 1'b1;
         if (w_seq_mismatch) begin
            r_seq_err_cnt <= r_seq_err_cnt + 1'b1;
         end
      end
   end

   assign o_seq_err_cnt = r_seq_err_cnt;
`endif

endmodule

// File: rtl/or_result_checker.sv
// Consumer end of the gate stimulus path. Accepts stimulus vectors with the
// gate-under-test output over a valid/ready handshake, registers them
// (stage 1), and hands them to or_result_cmp (stage 2) for checking.
// A sweep is 2**WIDTH accepted beats; done/pass report the outcome.
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in RUN and does not depend on in_valid.
// dbg_state exposes the FSM state for observation.
// Optional feature macro: CHECK_SEQ_EN (adds seq_err_cnt, vector order check).
module or_result_checker
   import or_result_checker_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_result,
   output logic             in_ready,
   output logic [CNT_W-1:0] total_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] first_err_data,
   output logic             first_err_valid,
   output logic             done,
   output logic             pass,
`ifdef CHECK_SEQ_EN
   output logic [CNT_W-1:0] seq_err_cnt,
`endif
   output logic [1:0]       dbg_state
);

   // Accept-count value at which the accepting beat is the last of the sweep
   localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'((2 ** WIDTH) - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_acc_cnt;
   logic             r_in_ready;
   logic             r_done;
   logic             r_pass;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_data;
   logic             r_s1_result;

   logic             w_accept;
   logic             w_clear;
   logic             w_pass_cond;
   logic [CNT_W-1:0] w_total_cnt;
   logic [CNT_W-1:0] w_err_cnt;
   logic [WIDTH-1:0] w_first_err_data;
   logic             w_first_err_valid;
`ifdef CHECK_SEQ_EN
   logic [CNT_W-1:0] w_seq_err_cnt;
`endif

   // Handshake and sweep-start decode; start is honoured only in IDLE or DONE
   always_comb begin
      w_accept = in_valid && r_in_ready;
      w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
`ifdef CHECK_SEQ_EN
      w_pass_cond = (w_err_cnt == '0) && (w_seq_err_cnt == '0);
`else
      w_pass_cond = (w_err_cnt == '0);
`endif
   end

   // Sweep control FSM with registered in_ready, done and pass
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_acc_cnt  <= '0;
         r_in_ready <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_RUN;
                  r_acc_cnt  <= '0;
                  r_in_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_acc_cnt <= r_acc_cnt + 1'b1;
                  // Drop ready right after the last beat so nothing extra is taken
                  if (r_acc_cnt == SWEEP_LAST) begin
                     r_state    <= ST_DRAIN;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               // Counters are final once the compare stage holds no beat
               if (!r_s1_valid) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_pass  <= w_pass_cond;
               end
            end
            ST_DONE: begin
               if (start) begin
                  r_state    <= ST_RUN;
                  r_acc_cnt  <= '0;
                  r_in_ready <= 1'b1;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: register the accepted vector and gate output; reset drops any beat in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_result <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_data   <= in_data;
            r_s1_result <= in_result;
         end
      end
   end

   or_result_cmp #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cmp (
      .clk               (clk),
      .rst               (rst),
      .i_clear           (w_clear),
      .i_valid           (r_s1_valid),
      .i_data            (r_s1_data),
      .i_result          (r_s1_result),
      .o_total_cnt       (w_total_cnt),
      .o_err_cnt         (w_err_cnt),
      .o_first_err_data  (w_first_err_data),
      .o_first_err_valid (w_first_err_valid)
`ifdef CHECK_SEQ_EN
      ,
      .o_seq_err_cnt     (w_seq_err_cnt)
`endif
   );

   assign in_ready        = r_in_ready;
   assign total_cnt       = w_total_cnt;
   assign err_cnt         = w_err_cnt;
   assign first_err_data  = w_first_err_data;
   assign first_err_valid = w_first_err_valid;
   assign done            = r_done;
   assign pass            = r_pass;
   assign dbg_state       = r_state;
`ifdef CHECK_SEQ_EN
   assign seq_err_cnt     = w_seq_err_cnt;
`endif

endmodule

// File: tb/tb_or_result_checker.sv
// Directed bench for or_result_checker: full sweeps with a correct gate,
// injected gate faults, random valid gaps, mid-sweep reset, restart from DONE
// and start/reset collisions. With CHECK_SEQ_EN a duplicated vector is sent.
module tb_or_result_checker;
   import or_result_checker_pkg::*;

   localparam int WIDTH = DEFAULT_WIDTH;
   localparam int CNT_W = WIDTH + 1;

   logic             clk;
   logic             rst;
   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_result;
   logic             in_ready;
   logic [CNT_W-1:0] total_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [WIDTH-1:0] first_err_data;
   logic             first_err_valid;
   logic             done;
   logic             pass;
   logic [1:0]       dbg_state;
`ifdef CHECK_SEQ_EN
   logic [CNT_W-1:0] seq_err_cnt;
`endif

   int n_vec;
   int n_err;

   or_result_checker #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_result       (in_result),
      .in_ready        (in_ready),
      .total_cnt       (total_cnt),
      .err_cnt         (err_cnt),
      .first_err_data  (first_err_data),
      .first_err_valid (first_err_valid),
      .done            (done),
      .pass            (pass),
`ifdef CHECK_SEQ_EN
      .seq_err_cnt     (seq_err_cnt),
`endif
      .dbg_state       (dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse start for one edge; returns at the following falling edge
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive a sweep of stop_at accepted beats. fault=1 corrupts the gate output
   // at 0x000 (forced 1) and 0x155 (forced 0). mid_start>=0 pulses start while
   // that beat index is offered. seq_dup sends 0x010 in place of 0x011.
   task automatic sweep(input bit gaps, input int fault, input int stop_at,
                        input int mid_start, input bit seq_dup);
      int               idx;
      int               cyc;
      bit               ready_now;
      bit               dropped;
      logic [WIDTH-1:0] v;
      idx     = 0;
      cyc     = 0;
      dropped = 1'b0;
      while (idx < stop_at && cyc < 20000) begin
         @(negedge clk);
         ready_now = in_ready;
         if (!ready_now) dropped = 1'b1;
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         v = WIDTH'(idx);
         if (seq_dup && idx == 'h011) v = 10'h010;
         in_data   = v;
         in_result = |v;
         if (fault == 1 && v == 10'h000) in_result = 1'b1;
         if (fault == 1 && v == 10'h155) in_result = 1'b0;
         start = (mid_start >= 0 && idx == mid_start) ? 1'b1 : 1'b0;
         @(posedge clk);
         if (in_valid && ready_now) idx++;
         cyc++;
      end
      start = 1'b0;
      check("sweep_accepts", idx, stop_at);
      if (stop_at == SWEEP_LEN) begin
         check("ready_held_during_run", 32'(dropped), 0);
         // Keep offering a beat: none may be taken after the final accept
         @(negedge clk);
         in_valid  = 1'b1;
         in_data   = 10'h3FF;
         in_result = 1'b1;
         check("ready_low_after_last", 32'(in_ready), 0);
         check("done_low_1_after_last", 32'(done), 0);
         @(negedge clk);
         check("total_final_at_2", total_cnt, SWEEP_LEN);
         check("done_low_2_after_last", 32'(done), 0);
         @(negedge clk);
         check("done_high_3_after_last", 32'(done), 1);
         check("total_no_extra_beat", total_cnt, SWEEP_LEN);
         in_valid = 1'b0;
      end else begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Directed steps
   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_result = 1'b0;
      do_reset();

      // Reset state
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_total", total_cnt, 0);
      check("rst_err", err_cnt, 0);
      check("rst_fed", first_err_data, 0);
      check("rst_fev", 32'(first_err_valid), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_state", dbg_state, 0);

      // Clean sweep, no gaps
      pulse_start();
      check("t1_ready_after_start", 32'(in_ready), 1);
      sweep(1'b0, 0, SWEEP_LEN, -1, 1'b0);
      check("t1_total", total_cnt, 1024);
      check("t1_err", err_cnt, 0);
      check("t1_fev", 32'(first_err_valid), 0);
      check("t1_pass", 32'(pass), 1);
      check("t1_state_done", dbg_state, 3);

      // Faulty gate at 0x000 and 0x155
      pulse_start();
      check("t2_total_cleared", total_cnt, 0);
      check("t2_done_cleared", 32'(done), 0);
      sweep(1'b0, 1, SWEEP_LEN, -1, 1'b0);
      check("t2_total", total_cnt, 1024);
      check("t2_err", err_cnt, 2);
      check("t2_fed", first_err_data, 10'h000);
      check("t2_fev", 32'(first_err_valid), 1);
      check("t2_pass", 32'(pass), 0);

      // Restart from DONE after an erroring run; gaps and an ignored mid-run start
      pulse_start();
      check("t3_err_cleared", err_cnt, 0);
      check("t3_fev_cleared", 32'(first_err_valid), 0);
      check("t3_pass_cleared", 32'(pass), 0);
      sweep(1'b1, 0, SWEEP_LEN, 300, 1'b0);
      check("t3_total", total_cnt, 1024);
      check("t3_err", err_cnt, 0);
      check("t3_fev", 32'(first_err_valid), 0);
      check("t3_pass", 32'(pass), 1);

      // Reset after 500 accepts of a faulty run, then a full clean sweep
      pulse_start();
      sweep(1'b0, 1, 500, -1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t4_rst_ready", 32'(in_ready), 0);
      check("t4_rst_total", total_cnt, 0);
      check("t4_rst_err", err_cnt, 0);
      check("t4_rst_fev", 32'(first_err_valid), 0);
      check("t4_rst_done", 32'(done), 0);
      check("t4_rst_state", dbg_state, 0);
      rst = 1'b0;
      @(negedge clk);
      check("t4_inflight_dropped", total_cnt, 0);
      pulse_start();
      sweep(1'b0, 0, SWEEP_LEN, -1, 1'b0);
      check("t4_total", total_cnt, 1024);
      check("t4_err", err_cnt, 0);
      check("t4_fev", 32'(first_err_valid), 0);
      check("t4_pass", 32'(pass), 1);

      // start and rst together in DONE: reset wins
      @(negedge clk);
      start = 1'b1;
      rst   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      check("t5_ready", 32'(in_ready), 0);
      check("t5_done", 32'(done), 0);
      check("t5_total", total_cnt, 0);
      check("t5_state", dbg_state, 0);

`ifdef CHECK_SEQ_EN
      // Vector 0x010 repeated in place of 0x011, gate output correct both times
      pulse_start();
      sweep(1'b0, 0, SWEEP_LEN, -1, 1'b1);
      check("t6_err", err_cnt, 0);
      check("t6_seq_err", seq_err_cnt, 1);
      check("t6_pass", 32'(pass), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
